pbit_sweep_scheduler: RTL and testbench

Sequences the enable inputs of an array of N_PBITS P-bits using graph-coloured Gibbs sampling. Only one colour group updates at a time. Before each group fires, the scheduler waits a programmable settle time so the weighted sums I_i and the Tanh LUT outputs of the other groups have settled. After every full sweep it snapshots the P-bit state vector. It sits between the host/control logic and the P-bit array, replacing a free-running common enable.

---
 rtl/pbit_sweep_scheduler_pkg.sv | 39 +++
 rtl/pbit_sweep_scheduler_if.sv | 40 ++++
 rtl/pbit_sweep_scheduler_color_decoder.sv | 33 +++
 rtl/pbit_sweep_scheduler.sv | 170 +++++++++++++++++
 tb/tb_pbit_sweep_scheduler.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/pbit_sweep_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pbit_sched_pkg                                                  |
// | Brief    : Shared types and helpers for the P-bit sweep scheduler.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package pbit_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_FIRE   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } sched_state_t;

    localparam int C_MAX_COLORS_DEFAULT = 4;
    localparam int C_MAP_W_MAX          = 1024;
    localparam int C_CW_MAX             = 8;

    function automatic bit is_valid_max_colors(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    localparam bit C_MAX_COLORS_OK = is_valid_max_colors(C_MAX_COLORS_DEFAULT);

    // Colour of P-bit idx from a packed map of cw-bit fields, zero-extended.
    function automatic logic [C_CW_MAX-1:0] color_of(
        input logic [C_MAP_W_MAX-1:0] map,
        input int unsigned            idx,
        input int unsigned            cw
    );
        logic [C_CW_MAX-1:0] mask;
        mask = (C_CW_MAX'(1) << cw) - C_CW_MAX'(1);
        return C_CW_MAX'(map >> (idx * cw)) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pbit_sweep_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pbit_sweep_scheduler_if                                         |
// | Brief    : Control, configuration and P-bit array signals of the scheduler.|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface pbit_sweep_scheduler_if #(
    parameter int N_PBITS    = 16,
    parameter int MAX_COLORS = 4,
    parameter int SETTLE_W   = 4,
    parameter int SWEEP_W    = 16
);
    localparam int CW = $clog2(MAX_COLORS);

    logic                  start;
    logic                  stop;
    logic [CW-1:0]         num_colors_m1;
    logic [N_PBITS*CW-1:0] color_map;
    logic [SETTLE_W-1:0]   settle_cycles;
    logic [SWEEP_W-1:0]    num_sweeps;
    logic [N_PBITS-1:0]    m_vec;

    logic [N_PBITS-1:0]    enable;
    logic                  busy;
    logic [N_PBITS-1:0]    sample;
    logic                  sample_valid;
    logic [SWEEP_W-1:0]    sweep_count;
    logic                  done;

    modport master (
        output start, stop, num_colors_m1, color_map, settle_cycles, num_sweeps, m_vec,
        input  enable, busy, sample, sample_valid, sweep_count, done
    );

    modport slave (
        input  start, stop, num_colors_m1, color_map, settle_cycles, num_sweeps, m_vec,
        output enable, busy, sample, sample_valid, sweep_count, done
    );
endinterface
`default_nettype wire

// File: rtl/pbit_sweep_scheduler_color_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pbit_color_decoder                                              |
// | Brief    : Enables every P-bit whose latched colour matches the firing one.|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pbit_color_decoder
    import pbit_sched_pkg::*;
#(
    parameter int N_PBITS = 16,
    parameter int CW      = 2
) (
    input  wire [N_PBITS*CW-1:0] i_color_map,
    input  wire [CW-1:0]         i_color,
    input  wire                  i_fire,
    output logic [N_PBITS-1:0]   o_enable
);

    if ((N_PBITS * CW > C_MAP_W_MAX) || (CW > C_CW_MAX)) begin : g_map_too_wide
        $error("colour map exceeds the width supported by color_of");
    end

    logic [C_MAP_W_MAX-1:0] w_map_ext;
    assign w_map_ext = C_MAP_W_MAX'(i_color_map);

    for (genvar gi = 0; gi < N_PBITS; gi++) begin : g_bit
        logic [C_CW_MAX-1:0] w_color;
        assign w_color      = color_of(w_map_ext, gi, CW);
        assign o_enable[gi] = i_fire && (w_color == C_CW_MAX'(i_color));
    end

endmodule
`default_nettype wire

// File: rtl/pbit_sweep_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pbit_sweep_scheduler                                            |
// | Brief    : Graph-coloured Gibbs sweep sequencer with per-sweep snapshots.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pbit_sweep_scheduler
    import pbit_sched_pkg::*;
#(
    parameter int N_PBITS    = 16,
    parameter int MAX_COLORS = C_MAX_COLORS_DEFAULT,
    parameter int SETTLE_W   = 4,
    parameter int SWEEP_W    = 16
) (
    input wire                    clk,
    input wire                    reset,
    pbit_sweep_scheduler_if.slave bus
);

    localparam int CW = $clog2(MAX_COLORS);

    if (!is_valid_max_colors(MAX_COLORS)) begin : g_bad_max_colors
        $error("MAX_COLORS must be a power of two and at least 2");
    end

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;
    logic [SETTLE_W-1:0]   r_cnt;
    logic [SETTLE_W-1:0]   w_cnt_nxt;
    logic [CW-1:0]         r_color;
    logic [CW-1:0]         w_color_nxt;

    logic [N_PBITS*CW-1:0] r_cfg_map;
    logic [CW-1:0]         r_cfg_ncm1;
    logic [SETTLE_W-1:0]   r_cfg_settle;
    logic [SWEEP_W-1:0]    r_cfg_sweeps;

    logic                  r_stop_pending;
    logic [SWEEP_W-1:0]    r_sweep_count;
    logic [N_PBITS-1:0]    r_sample;
    logic                  r_sample_valid;

    logic                  w_load_cfg;
    logic                  w_take_sample;
    logic                  w_enter_slot;
    logic                  w_fire;
    logic [SETTLE_W-1:0]   w_settle;
    logic [SWEEP_W-1:0]    w_sweep_inc;

    assign w_sweep_inc = r_sweep_count + SWEEP_W'(1);
    // In IDLE the config registers are not loaded yet, so the first slot uses the live input.
    assign w_settle    = (r_state == ST_IDLE) ? bus.settle_cycles : r_cfg_settle;
    assign w_fire      = (r_state == ST_FIRE);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_color_nxt   = r_color;
        w_load_cfg    = 1'b0;
        w_take_sample = 1'b0;
        w_enter_slot  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_load_cfg   = 1'b1;
                    w_color_nxt  = '0;
                    w_enter_slot = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_FIRE;
                end else begin
                    w_cnt_nxt = r_cnt - SETTLE_W'(1);
                end
            end
            ST_FIRE: begin
                if (r_color == r_cfg_ncm1) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_color_nxt  = r_color + CW'(1);
                    w_enter_slot = 1'b1;
                end
            end
            ST_SAMPLE: begin
                w_take_sample = 1'b1;
                if (r_stop_pending || bus.stop ||
                    ((r_cfg_sweeps != '0) && (w_sweep_inc == r_cfg_sweeps))) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_color_nxt  = '0;
                    w_enter_slot = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A zero settle time skips SETTLE and fires on the very next cycle.
        if (w_enter_slot) begin
            if (w_settle == '0) begin
                w_state_nxt = ST_FIRE;
            end else begin
                w_state_nxt = ST_SETTLE;
                w_cnt_nxt   = w_settle - SETTLE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_color        <= '0;
            r_cfg_map      <= '0;
            r_cfg_ncm1     <= '0;
            r_cfg_settle   <= '0;
            r_cfg_sweeps   <= '0;
            r_stop_pending <= 1'b0;
            r_sweep_count  <= '0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_color        <= w_color_nxt;
            r_sample_valid <= w_take_sample;

            if (w_load_cfg) begin
                r_cfg_map      <= bus.color_map;
                r_cfg_ncm1     <= bus.num_colors_m1;
                r_cfg_settle   <= bus.settle_cycles;
                r_cfg_sweeps   <= bus.num_sweeps;
                r_sweep_count  <= '0;
                r_stop_pending <= 1'b0;
            end else begin
                if (bus.stop && (r_state != ST_IDLE)) begin
                    r_stop_pending <= 1'b1;
                end
                if (w_take_sample) begin
                    r_sample      <= bus.m_vec;
                    r_sweep_count <= w_sweep_inc;
                end
            end
        end
    end

    pbit_color_decoder #(
        .N_PBITS (N_PBITS),
        .CW      (CW)
    ) u_decoder (
        .i_color_map (r_cfg_map),
        .i_color     (r_color),
        .i_fire      (w_fire),
        .o_enable    (bus.enable)
    );

    assign bus.busy         = (r_state != ST_IDLE);
    assign bus.done         = (r_state == ST_DONE);
    assign bus.sample       = r_sample;
    assign bus.sample_valid = r_sample_valid;
    assign bus.sweep_count  = r_sweep_count;

endmodule
`default_nettype wire

// File: tb/tb_pbit_sweep_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pbit_sweep_scheduler                                         |
// | Brief    : Table and random runs against a sweep-timeline reference model. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_pbit_sweep_scheduler;

    localparam int N  = 4;
    localparam int MC = 4;
    localparam int CW = 2;
    localparam int SW = 4;
    localparam int WW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pbit_sweep_scheduler_if #(.N_PBITS(N), .MAX_COLORS(MC), .SETTLE_W(SW), .SWEEP_W(WW)) bus_if ();

    pbit_sweep_scheduler #(.N_PBITS(N), .MAX_COLORS(MC), .SETTLE_W(SW), .SWEEP_W(WW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    typedef struct {
        int         ncm1;
        int         map;
        int         s;
        int         nsw;
        int         stop_at;
        int         exp_done_t;
        int         exp_count;
        logic [N-1:0] exp_first_en;
    } vec_t;

    int n_vec      = 0;
    int n_miss     = 0;
    int prev_count = 0;

    task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, t, act, exp);
        end
    endtask

    function automatic logic [N-1:0] grp_mask(input int map, input int c);
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++)
            if (((map >> (CW * i)) & ((1 << CW) - 1)) == c) m[i] = 1'b1;
        return m;
    endfunction

    // One run from its start cycle (t=0) to the idle cycle after done; every cycle checked
    // against the sweep timeline: C slots of S idle cycles plus one fire, then a sample cycle.
    task automatic do_run(input int ncm1, input int map, input int s, input int nsw,
                          input int stop_at, input bit noisy,
                          output int done_t, output int final_cnt, output logic [N-1:0] first_en);
        int c, l, jend, e, p;
        logic [N-1:0] exp_en;
        logic         exp_sv;
        int           exp_cnt;
        logic [N-1:0] mv [$];
        c = ncm1 + 1;
        l = c * (s + 1) + 1;
        jend = 0;
        while (!((nsw != 0 && jend + 1 == nsw) || (stop_at >= 1 && (jend + 1) * l >= stop_at))
               && jend < 1000)
            jend++;
        e = (jend + 1) * l;
        done_t = -1;
        final_cnt = -1;
        first_en = 'x;
        for (int t = 0; t <= e + 2; t++) begin
            bus_if.stop = (stop_at > 0 && t == stop_at);
            if (t == 0) begin
                bus_if.start         = 1'b1;
                bus_if.num_colors_m1 = CW'(ncm1);
                bus_if.color_map     = (N * CW)'(map);
                bus_if.settle_cycles = SW'(s);
                bus_if.num_sweeps    = WW'(nsw);
            end else begin
                bus_if.start = noisy && (t <= e + 1) && ($urandom_range(0, 3) == 0);
                if (noisy) begin
                    bus_if.num_colors_m1 = CW'($urandom);
                    bus_if.color_map     = (N * CW)'($urandom);
                    bus_if.settle_cycles = SW'($urandom);
                    bus_if.num_sweeps    = WW'($urandom);
                end
            end
            bus_if.m_vec = N'($urandom);
            mv.push_back(bus_if.m_vec);
            @(negedge clk);

            exp_en = '0;
            exp_sv = 1'b0;
            if (t == 0) begin
                exp_cnt = prev_count;
            end else if (t <= e) begin
                p = (t - 1) % l;
                if (p < c * (s + 1) && (p % (s + 1)) == s) exp_en = grp_mask(map, p / (s + 1));
                exp_cnt = (t - 1) / l;
                exp_sv  = (t > 1) && ((t - 1) % l == 0);
            end else begin
                exp_cnt = jend + 1;
                exp_sv  = (t == e + 1);
            end
            chk("enable", t, 32'(bus_if.enable), 32'(exp_en));
            chk("busy", t, 32'(bus_if.busy), 32'(t >= 1 && t <= e + 1));
            chk("done", t, 32'(bus_if.done), 32'(t == e + 1));
            chk("sample_valid", t, 32'(bus_if.sample_valid), 32'(exp_sv));
            chk("sweep_count", t, 32'(bus_if.sweep_count), 32'(exp_cnt));
            if (exp_sv) chk("sample", t, 32'(bus_if.sample), 32'(mv[t - 1]));

            if (bus_if.done === 1'b1 && done_t < 0) done_t = t;
            if (t == e + 2) final_cnt = int'(bus_if.sweep_count);
            if (t == s + 1) first_en = bus_if.enable;
            @(posedge clk);
            #1;
        end
        bus_if.start = 1'b0;
        bus_if.stop  = 1'b0;
        prev_count   = jend + 1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog cycle=0 got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t         vecs [9];
        int           dt, fc, ncm1, map, s, nsw, l, stop_at;
        logic [N-1:0] fe;

        vecs[0] = '{1, 'h44, 2, 1, 0,  8, 1, 4'b0101};
        vecs[1] = '{2, 'h24, 0, 2, 0,  9, 2, 4'b1001};
        vecs[2] = '{1, 'h44, 1, 0, 23, 26, 5, 4'b0101};
        vecs[3] = '{2, 'h88, 3, 1, 0, 14, 1, 4'b0101};
        vecs[4] = '{1, 'h93, 1, 3, 0, 16, 3, 4'b0010};
        vecs[5] = '{3, 'hE4, 15, 1, 0, 66, 1, 4'b0001};
        vecs[6] = '{0, 'h00, 0, 3, 0,  7, 3, 4'b1111};
        vecs[7] = '{1, 'h44, 2, 4, 2,  8, 1, 4'b0101};
        vecs[8] = '{1, 'h44, 2, 0, 14, 15, 2, 4'b0101};

        reset                = 1'b1;
        bus_if.start         = 1'b0;
        bus_if.stop          = 1'b0;
        bus_if.num_colors_m1 = '0;
        bus_if.color_map     = '0;
        bus_if.settle_cycles = '0;
        bus_if.num_sweeps    = '0;
        bus_if.m_vec         = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_enable", 0, 32'(bus_if.enable), 32'd0);
        chk("reset_busy", 0, 32'(bus_if.busy), 32'd0);
        chk("reset_sample", 0, 32'(bus_if.sample), 32'd0);
        chk("reset_sample_valid", 0, 32'(bus_if.sample_valid), 32'd0);
        chk("reset_sweep_count", 0, 32'(bus_if.sweep_count), 32'd0);
        chk("reset_done", 0, 32'(bus_if.done), 32'd0);
        @(posedge clk);
        #1;

        for (int v = 0; v < 9; v++) begin
            do_run(vecs[v].ncm1, vecs[v].map, vecs[v].s, vecs[v].nsw, vecs[v].stop_at,
                   v != 0, dt, fc, fe);
            chk("table_done_cycle", v, 32'(dt), 32'(vecs[v].exp_done_t));
            chk("table_final_count", v, 32'(fc), 32'(vecs[v].exp_count));
            chk("table_first_enable", v, 32'(fe), 32'(vecs[v].exp_first_en));
        end

        // Reset asserted while colour 0 of sweep 3 is firing.
        for (int t = 0; t <= 17; t++) begin
            bus_if.start         = (t == 0);
            bus_if.num_colors_m1 = 2'd1;
            bus_if.color_map     = 8'h44;
            bus_if.settle_cycles = 4'd2;
            bus_if.num_sweeps    = 16'd0;
            bus_if.m_vec         = N'($urandom);
            if (t == 17) reset = 1'b1;
            @(negedge clk);
            if (t == 17) begin
                chk("pre_reset_enable", t, 32'(bus_if.enable), 32'b0101);
                chk("pre_reset_count", t, 32'(bus_if.sweep_count), 32'd2);
            end
            @(posedge clk);
            #1;
        end
        reset        = 1'b0;
        bus_if.start = 1'b0;
        @(negedge clk);
        chk("post_reset_enable", 18, 32'(bus_if.enable), 32'd0);
        chk("post_reset_busy", 18, 32'(bus_if.busy), 32'd0);
        chk("post_reset_count", 18, 32'(bus_if.sweep_count), 32'd0);
        chk("post_reset_sample_valid", 18, 32'(bus_if.sample_valid), 32'd0);
        chk("post_reset_done", 18, 32'(bus_if.done), 32'd0);
        @(posedge clk);
        #1;
        prev_count = 0;
        do_run(1, 'h44, 2, 1, 0, 1'b0, dt, fc, fe);
        chk("after_reset_done_cycle", 0, 32'(dt), 32'd8);
        chk("after_reset_count", 0, 32'(fc), 32'd1);

        for (int r = 0; r < 25; r++) begin
            ncm1 = $urandom_range(0, 3);
            map  = $urandom_range(0, 255);
            s    = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 5);
            nsw  = $urandom_range(0, 4);
            l    = (ncm1 + 1) * (s + 1) + 1;
            if (nsw == 0)
                stop_at = $urandom_range(1, 4 * l);
            else
                stop_at = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, nsw * l + 2);
            do_run(ncm1, map, s, nsw, stop_at, 1'b1, dt, fc, fe);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
